// File: rtl/lcd_ctrl_param.sv
// rtl/lcd_ctrl_param.sv - parametrised image controller: ROM load, 2x2 window ops, RAM write-out
module lcd_ctrl_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);
    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [XW-1:0] X_MID = XW'(IMG_W / 2);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MID = YW'(IMG_H / 2);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_EXEC1 = 3'd3;
    localparam logic [2:0] S_EXEC2 = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]    state;
    logic [3:0]    cmd_r;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] pix [N];
    logic [DW-1:0] wa, wb, wc, wd;

    logic [XW-1:0] xm1;
    logic [YW-1:0] ym1;
    logic [AW-1:0] idx_a, idx_b, idx_c, idx_d;
    logic [DW-1:0] max_ab, max_cd, max_all, min_ab, min_cd, min_all, avg;
    logic [DW+1:0] sum;
    logic          two_cycle;

    // Image dimensions are powers of two, so the row-major address is just {y, x}.
    assign xm1   = x - 1'b1;
    assign ym1   = y - 1'b1;
    assign idx_a = {ym1, xm1};
    assign idx_b = {ym1, x};
    assign idx_c = {y, xm1};
    assign idx_d = {y, x};

    assign max_ab  = (wa > wb) ? wa : wb;
    assign max_cd  = (wc > wd) ? wc : wd;
    assign max_all = (max_ab > max_cd) ? max_ab : max_cd;
    assign min_ab  = (wa < wb) ? wa : wb;
    assign min_cd  = (wc < wd) ? wc : wd;
    assign min_all = (min_ab < min_cd) ? min_ab : min_cd;
    assign sum     = {2'b00, wa} + {2'b00, wb} + {2'b00, wc} + {2'b00, wd};
    assign avg     = sum[DW+1:2];

    assign two_cycle = (cmd_r >= 4'd5) && (cmd_r <= 4'd9);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_INIT;
            cmd_r      <= '0;
            x          <= X_MID;
            y          <= Y_MID;
            wa         <= '0;
            wb         <= '0;
            wc         <= '0;
            wd         <= '0;
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_D     <= '0;
            IRAM_A     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            for (int i = 0; i < N; i++) pix[i] <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    IROM_rd <= 1'b1;
                    IROM_A  <= '0;
                    state   <= S_LOAD;
                end
                S_LOAD: begin
                    pix[IROM_A] <= IROM_Q;
                    if (IROM_A == LAST) begin
                        IROM_rd <= 1'b0;
                        IROM_A  <= '0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        IROM_A <= IROM_A + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid && !busy) begin
                        busy  <= 1'b1;
                        cmd_r <= cmd;
                        if (cmd == 4'd0) begin
                            IRAM_valid <= 1'b1;
                            IRAM_A     <= '0;
                            IRAM_D     <= pix[0];
                            state      <= S_WRITE;
                        end else begin
                            state <= S_EXEC1;
                        end
                    end
                end
                S_EXEC1: begin
                    case (cmd_r)
                        4'd1: if (y != YW'(1)) y <= ym1;
                        4'd2: if (y != Y_MAX)  y <= y + 1'b1;
                        4'd3: if (x != XW'(1)) x <= xm1;
                        4'd4: if (x != X_MAX)  x <= x + 1'b1;
                        4'd10: begin
                            x <= X_MID;
                            y <= Y_MID;
                        end
                        default: begin
                            wa <= pix[idx_a];
                            wb <= pix[idx_b];
                            wc <= pix[idx_c];
                            wd <= pix[idx_d];
                        end
                    endcase
                    if (two_cycle) begin
                        state <= S_EXEC2;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_EXEC2: begin
                    case (cmd_r)
                        4'd5: begin
                            pix[idx_a] <= max_all;
                            pix[idx_b] <= max_all;
                            pix[idx_c] <= max_all;
                            pix[idx_d] <= max_all;
                        end
                        4'd6: begin
                            pix[idx_a] <= min_all;
                            pix[idx_b] <= min_all;
                            pix[idx_c] <= min_all;
                            pix[idx_d] <= min_all;
                        end
                        4'd7: begin
                            pix[idx_a] <= avg;
                            pix[idx_b] <= avg;
                            pix[idx_c] <= avg;
                            pix[idx_d] <= avg;
                        end
                        4'd8: begin
                            pix[idx_a] <= wc;
                            pix[idx_b] <= wa;
                            pix[idx_d] <= wb;
                            pix[idx_c] <= wd;
                        end
                        4'd9: begin
                            pix[idx_a] <= wb;
                            pix[idx_b] <= wd;
                            pix[idx_d] <= wc;
                            pix[idx_c] <= wa;
                        end
                        default: ;
                    endcase
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_WRITE: begin
                    if (IRAM_A == LAST) begin
                        IRAM_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        IRAM_A <= IRAM_A + 1'b1;
                        IRAM_D <= pix[IRAM_A + 1'b1];
                    end
                end
                S_DONE: ;
                default: state <= S_INIT;
            endcase
        end
    end
endmodule
